// File: rtl/c432_lock_pkg.sv
// Shared lock types and widths for the c432 key loader and the locked core.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional build macro: C432_KEY_PARITY_EN adds a trailing even-parity bit to the frame.
package c432_lock_pkg;

   localparam int P_W   = 4;              // MUX-lock key width (p[3:0])
   localparam int X_W   = 7;              // XOR-lock key width (x[6:0])
   localparam int KEY_W = P_W + X_W;      // applied key width

`ifdef C432_KEY_PARITY_EN
   localparam int FRAME_W = KEY_W + 1;    // key bits plus one even-parity bit
`else
   localparam int FRAME_W = KEY_W;
`endif

   // Wide enough to hold FRAME_W itself so the bit counter never wraps.
   localparam int CNT_W = $clog2(FRAME_W + 1);

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [P_W-1:0] p;
   } key_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      ARMED,
      ERROR
   } ldr_state_e;

endpackage

// File: rtl/c432_key_loader_if.sv
// Key-store link and core key bus of the c432 key loader, bundled as one interface.
// Latency: n/a (wires only).
// Backpressure: key_valid/key_ready serial link; a bit moves only when both are high.
// Signals: load_start, key_valid, key_bit (store -> loader);
//          key_ready, key_p, key_x, key_armed, key_err (loader -> store/core).
interface c432_key_loader_if;
   import c432_lock_pkg::*;

   logic           load_start;
   logic           key_valid;
   logic           key_bit;
   logic           key_ready;
   logic [P_W-1:0] key_p;
   logic [X_W-1:0] key_x;
   logic           key_armed;
   logic           key_err;

   // Key store / test side.
   modport master (
      output load_start, key_valid, key_bit,
      input  key_ready, key_p, key_x, key_armed, key_err
   );

   // Loader side.
   modport slave (
      input  load_start, key_valid, key_bit,
      output key_ready, key_p, key_x, key_armed, key_err
   );

endinterface

// File: rtl/c432_key_shreg.sv
// LSB-first serial-in shift register with synchronous clear and saturating bit counter.
// Latency: a shifted bit is visible in data_o the cycle after shift_i.
// Backpressure: none; shifts are ignored once count_o reaches W, clear has priority over shift.
// Ports: clk, rst_n, clr_i, shift_i, bit_i -> data_o[W-1:0], count_o[CW-1:0].
module c432_key_shreg #(
   parameter int W  = 11,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          shift_i,
   input  logic          bit_i,
   output logic [W-1:0]  data_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  data_q,  data_d;
   logic [CW-1:0] count_q, count_d;

   // Bits enter at the top and move down, so after W shifts the first bit sits in data[0].
   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      if (clr_i) begin
         data_d  = '0;
         count_d = '0;
      end else if (shift_i && (count_q != CW'(W))) begin
         data_d  = {bit_i, data_q[W-1:1]};
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   assign data_o  = data_q;
   assign count_o = count_q;

endmodule

// File: rtl/c432_key_loader.sv
// Loads the c432 unlock key serially, checks it, then applies it to the core in one step.
// Latency: load_start -> first accept 1 cycle; last accepted bit -> key_armed 2 cycles.
// Backpressure: key_ready high only while loading; key_valid is ignored in every other state.
// Ports: clk, rst_n, kif (slave): load_start/key_valid/key_bit in;
//        key_ready/key_p/key_x/key_armed/key_err out, all registered.
// Build macro: C432_KEY_PARITY_EN -> 12-bit frame with even parity in bit 11; otherwise 11 bits, always passes.
module c432_key_loader
   import c432_lock_pkg::*;
#(
   parameter logic [KEY_W-1:0] DECOY_KEY = 11'h000
) (
   input  logic               clk,
   input  logic               rst_n,
   c432_key_loader_if.slave   kif
);

   ldr_state_e         state_q, state_d;
   key_t               key_q,   key_d;
   logic               armed_q, armed_d;
   logic               err_q,   err_d;
   logic               ready_q, ready_d;

   logic               sh_clr;
   logic               sh_shift;
   logic [FRAME_W-1:0] sh_data;
   logic [CNT_W-1:0]   sh_count;
   logic               xfer;
   logic               frame_ok;

   c432_key_shreg #(
      .W  (FRAME_W),
      .CW (CNT_W)
   ) u_shreg (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (sh_clr),
      .shift_i (sh_shift),
      .bit_i   (kif.key_bit),
      .data_o  (sh_data),
      .count_o (sh_count)
   );

`ifdef C432_KEY_PARITY_EN
   // Even parity over the whole frame: XOR of all bits must be zero.
   assign frame_ok = ~(^sh_data);
`else
   assign frame_ok = 1'b1;
`endif

   assign xfer = kif.key_valid && ready_q;

   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      armed_d  = armed_q;
      err_d    = err_q;
      sh_clr   = 1'b0;
      sh_shift = 1'b0;

      case (state_q)
         IDLE: begin
         end
         LOAD: begin
            if (xfer) begin
               sh_shift = 1'b1;
               if (sh_count == CNT_W'(FRAME_W - 1)) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (frame_ok) begin
               state_d = ARMED;
               key_d   = key_t'(sh_data[KEY_W-1:0]);
               armed_d = 1'b1;
            end else begin
               state_d = ERROR;
               key_d   = key_t'(DECOY_KEY);
               armed_d = 1'b0;
               err_d   = 1'b1;
            end
         end
         ARMED: begin
         end
         ERROR: begin
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A (re)start overrides everything above, including a final bit arriving this
      // same cycle: the old key is withdrawn before any new bit can be accepted.
      if (kif.load_start) begin
         state_d  = LOAD;
         sh_clr   = 1'b1;
         sh_shift = 1'b0;
         key_d    = key_t'(DECOY_KEY);
         armed_d  = 1'b0;
         err_d    = 1'b0;
      end
   end

   // Registered ready tracks the state being entered, so it drops right after the last bit.
   assign ready_d = (state_d == LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= key_t'(DECOY_KEY);
         armed_q <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         armed_q <= armed_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

   assign kif.key_ready = ready_q;
   assign kif.key_p     = key_q.p;
   assign kif.key_x     = key_q.x;
   assign kif.key_armed = armed_q;
   assign kif.key_err   = err_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// Self-checking bench for c432_key_loader: queue-based frame model checked every cycle,
// plus hand-computed checks at the key points of each directed scenario.
module tb_c432_key_loader;
   import c432_lock_pkg::*;

   localparam int L   = FRAME_W;
   localparam bit PAR = (FRAME_W == KEY_W + 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   c432_key_loader_if kif();

   c432_key_loader #(.DECOY_KEY(11'h000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kif   (kif)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit done        = 1'b0;

   // ---------------- behavioural model ----------------
   // A load collects bits in a queue; once L bits are in, the key is judged on the next
   // edge and becomes visible after it. Decoy key is zero.
   bit          m_loading = 1'b0;
   bit          m_pending = 1'b0;
   bit          m_armed   = 1'b0;
   bit          m_err     = 1'b0;
   logic [10:0] m_key     = 11'h000;
   bit          m_bits[$];
   logic [11:0] m_frame;
   int          m_ones;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_loading = 1'b0;
         m_pending = 1'b0;
         m_armed   = 1'b0;
         m_err     = 1'b0;
         m_key     = 11'h000;
         m_bits.delete();
      end else begin
         if (m_pending) begin
            m_pending = 1'b0;
            m_frame   = 12'h000;
            m_ones    = 0;
            for (int k = 0; k < m_bits.size(); k++) begin
               m_frame[k] = m_bits[k];
               m_ones     = m_ones + int'(m_bits[k]);
            end
            if (!PAR || (m_ones % 2 == 0)) begin
               m_armed = 1'b1;
               m_key   = m_frame[10:0];
            end else begin
               m_err   = 1'b1;
               m_armed = 1'b0;
               m_key   = 11'h000;
            end
         end
         if (kif.load_start) begin
            m_loading = 1'b1;
            m_pending = 1'b0;
            m_bits.delete();
            m_armed   = 1'b0;
            m_err     = 1'b0;
            m_key     = 11'h000;
         end else if (m_loading && kif.key_valid) begin
            m_bits.push_back(kif.key_bit);
            if (m_bits.size() == L) begin
               m_loading = 1'b0;
               m_pending = 1'b1;
            end
         end
      end
   end

   // Per-cycle compare, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!done) begin
            vectors++;
            if ({kif.key_ready, kif.key_armed, kif.key_err, kif.key_x, kif.key_p} !==
                {m_loading, m_armed, m_err, m_key}) begin
               miscompares++;
               $display("FAIL cycle@%0t: dut rdy=%b armed=%b err=%b key=%h, model rdy=%b armed=%b err=%b key=%h",
                        $time, kif.key_ready, kif.key_armed, kif.key_err, {kif.key_x, kif.key_p},
                        m_loading, m_armed, m_err, m_key);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_load();
      kif.load_start = 1'b1;
      tick();
      kif.load_start = 1'b0;
   endtask

   function automatic logic [11:0] good(input logic [10:0] k);
      return {^k, k};
   endfunction

   function automatic logic [11:0] bad(input logic [10:0] k);
      return {~(^k), k};
   endfunction

   // Sends frame bits lo..hi; with rnd set, key_valid toggles randomly between offers.
   task automatic send_range(input logic [11:0] f, input int lo, input int hi, input bit rnd);
      int  i;
      int  guard;
      bit  acc;
      i     = lo;
      guard = 0;
      while (i <= hi && guard < 400) begin
         kif.key_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         kif.key_bit   = f[i];
         acc           = kif.key_valid && kif.key_ready;
         tick();
         if (acc) i++;
         guard++;
      end
      kif.key_valid = 1'b0;
      kif.key_bit   = 1'b0;
      if (guard >= 400) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: sent %0d bits, required %0d", i - lo, hi - lo + 1);
      end
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      kif.load_start = 1'b0;
      kif.key_valid  = 1'b0;
      kif.key_bit    = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", {2'b0, kif.key_ready, kif.key_armed, kif.key_err, kif.key_x, kif.key_p}, 16'h0000);
      rst_n = 1'b1;
      tick();

      // 1: load 5A3, armed two cycles after the last transfer
      pulse_load();
      chk("t1_ready_after_start", 16'(kif.key_ready), 16'h1);
      send_range(good(11'h5A3), 0, L - 1, 1'b0);
      chk("t1_not_yet_armed", {14'h0, kif.key_ready, kif.key_armed}, 16'h0);
      tick();
      chk("t1_key_p", 16'(kif.key_p), 16'h3);
      chk("t1_key_x", 16'(kif.key_x), 16'h5A);
      chk("t1_armed", 16'(kif.key_armed), 16'h1);

      // 4: restart from ARMED withdraws the key at once
      pulse_load();
      chk("t4_decoy_armed", {4'h0, kif.key_armed, kif.key_x, kif.key_p}, 16'h0000);
      chk("t4_ready", 16'(kif.key_ready), 16'h1);
      send_range(good(11'h0A5), 0, L - 2, 1'b0);
      tick();
      chk("t4_partial", {4'h0, kif.key_armed, kif.key_x, kif.key_p}, 16'h0000);
      send_range(good(11'h0A5), L - 1, L - 1, 1'b0);
      tick();
      chk("t4_new_key", {4'h0, kif.key_armed, kif.key_x, kif.key_p}, 16'h08A5);

      // 3: abort after 6 ones, then load 0F0
      pulse_load();
      send_range(12'hFFF, 0, 5, 1'b0);
      pulse_load();
      send_range(good(11'h0F0), 0, L - 1, 1'b0);
      tick();
      chk("t3_key", {4'h0, kif.key_armed, kif.key_x, kif.key_p}, 16'h08F0);

      // 2: parity failure (parity build only)
      if (PAR) begin
         pulse_load();
         send_range(bad(11'h5A3), 0, L - 1, 1'b0);
         tick();
         chk("t2_err", {3'h0, kif.key_err, kif.key_armed, kif.key_x, kif.key_p}, 16'h1000);
         pulse_load();
         chk("t2_err_cleared", 16'(kif.key_err), 16'h0);
      end

      // 5: reset mid-load
      pulse_load();
      send_range(12'hFFF, 0, 4, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t5_reset_now", {4'h0, kif.key_ready, kif.key_x, kif.key_p}, 16'h0000);
      chk("t5_reset_armed", 16'(kif.key_armed), 16'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 6a: key_valid while idle is ignored
      for (int c = 0; c < 6; c++) begin
         kif.key_valid = 1'b1;
         kif.key_bit   = 1'($urandom_range(0, 1));
         tick();
      end
      kif.key_valid = 1'b0;
      chk("t6_idle_ignored", {14'h0, kif.key_ready, kif.key_armed}, 16'h0);

      // 5 (cont.): a full load after the reset succeeds
      pulse_load();
      send_range(good(11'h3C5), 0, L - 1, 1'b0);
      tick();
      chk("t5_reload", {4'h0, kif.key_armed, kif.key_x, kif.key_p}, 16'h0BC5);

      // 6b: random key_valid during a load of 7FF
      pulse_load();
      send_range(good(11'h7FF), 0, L - 1, 1'b1);
      tick();
      chk("t6_key_7ff", {4'h0, kif.key_armed, kif.key_x, kif.key_p}, 16'h0FFF);

      // load_start on the same cycle as the final transfer: restart wins
      pulse_load();
      send_range(good(11'h0A5), 0, L - 2, 1'b0);
      kif.key_valid  = 1'b1;
      kif.key_bit    = good(11'h0A5) >> (L - 1);
      kif.load_start = 1'b1;
      tick();
      kif.key_valid  = 1'b0;
      kif.load_start = 1'b0;
      chk("t7_restart_ready", {14'h0, kif.key_ready, kif.key_armed}, 16'h2);
      tick();
      tick();
      chk("t7_no_check", {14'h0, kif.key_ready, kif.key_armed}, 16'h2);

      repeat (3) tick();
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global bound so a stuck handshake cannot hang the run.
   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
      $fatal(1);
   end

endmodule
